xorshift_engine: RTL and testbench

XORSHIFT_ENGINE -- requirements
Module: xorshift_engine

---
 rtl/xorshift_engine.sv | 130 +++++++++++++
 tb/tb_xorshift_engine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/xorshift_engine.sv
// xorshift_engine: multi-round xorshift pseudo-random word generator with a
// start/done/valid/ack handshake. The generator state persists between
// requests, so successive results form one continuous xorshift sequence.
// Optional build macro: XS_ZERO_SEED_GUARD_EN replaces an all-zero seed
// with 1. An all-zero state is a fixed point of xorshift and would otherwise
// yield zeros forever.
module xorshift_engine #(
  parameter int              WIDTH        = 32,
  parameter int              SHIFT_ROUNDS = 4,
  parameter int              SH_A         = 13,
  parameter int              SH_B         = 17,
  parameter int              SH_C         = 5,
  parameter logic [WIDTH-1:0] RESET_SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [WIDTH-1:0] rand_out
);

  localparam int CntW = $clog2(SHIFT_ROUNDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    XA,
    XB,
    XC,
    DONE,
    WAIT_ACK
  } XsState;

  XsState fsmState_q, fsmState_d;

  logic [WIDTH-1:0] rngState_q, rngState_d;
  logic [CntW-1:0]  roundCnt_q, roundCnt_d;
  logic [WIDTH-1:0] randOut_q, randOut_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] seedEff;
  logic             lastRound;

`ifdef XS_ZERO_SEED_GUARD_EN
  assign seedEff = (seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
`else
  assign seedEff = seed;
`endif

  assign lastRound = !(roundCnt_q < CntW'(SHIFT_ROUNDS - 1));

  // FSM state register; reset returns to IDLE asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsmState_q <= IDLE;
    else     fsmState_q <= fsmState_d;
  end

  // Next-state logic: one XA/XB/XC triple per round, then hold the result for ack
  always_comb begin
    fsmState_d = fsmState_q;
    case (fsmState_q)
      IDLE:     if (start) fsmState_d = XA;
      XA:       fsmState_d = XB;
      XB:       fsmState_d = XC;
      XC:       fsmState_d = lastRound ? DONE : XA;
      DONE:     fsmState_d = ack ? IDLE : WAIT_ACK;
      WAIT_ACK: if (ack) fsmState_d = IDLE;
      default:  fsmState_d = IDLE;
    endcase
  end

  // Status outputs decoded straight from the FSM state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (fsmState_q)
      XA, XB, XC: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // Datapath next values: seed load in IDLE, one shift-xor per busy state, capture on the final XC
  always_comb begin
    rngState_d = rngState_q;
    roundCnt_d = roundCnt_q;
    randOut_d  = randOut_q;
    valid_d    = valid_q;
    case (fsmState_q)
      IDLE: begin
        roundCnt_d = '0;
        if (seed_load) rngState_d = seedEff;
      end
      XA: rngState_d = rngState_q ^ (rngState_q << SH_A);
      XB: rngState_d = rngState_q ^ (rngState_q >> SH_B);
      XC: begin
        rngState_d = rngState_q ^ (rngState_q << SH_C);
        roundCnt_d = roundCnt_q + 1'b1;
        if (lastRound) begin
          randOut_d = rngState_d;
          valid_d   = 1'b1;
        end
      end
      default: ;
    endcase
    if (valid_q && ack) valid_d = 1'b0;
  end

  // Datapath registers; reset restores the seed and clears the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rngState_q <= RESET_SEED;
      roundCnt_q <= '0;
      randOut_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      rngState_q <= rngState_d;
      roundCnt_q <= roundCnt_d;
      randOut_q  <= randOut_d;
      valid_q    <= valid_d;
    end
  end

  assign valid    = valid_q;
  assign rand_out = randOut_q;

endmodule

// File: tb/tb_xorshift_engine.sv
// tb_xorshift_engine: scoreboard bench for xorshift_engine.
// Two instances share the request inputs:
//   dutA uses SHIFT_ROUNDS=1 and is checked against hand-computed words.
//   dutB uses the default configuration and is checked against a reference xorshift32.
// Each has its own ack input and its own monitor.
module tb_xorshift_engine;

  localparam int RoundsA = 1;
  localparam int RoundsB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        seedLoad;
  logic [31:0] seed;
  logic        ackA, ackB;
  logic        busyA, doneA, validA;
  logic        busyB, doneB, validB;
  logic [31:0] randA, randB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] value;
    longint      startTime;
  } ExpT;

  ExpT qA[$];
  ExpT qB[$];

  logic [31:0] stA, stB;
  logic [31:0] holdA = '0, holdB = '0;
  logic        prevDoneA = 1'b0, prevDoneB = 1'b0;

  xorshift_engine #(.WIDTH(32), .SHIFT_ROUNDS(RoundsA)) dutA (
    .clk(clk), .rst(rst), .start(start), .seed_load(seedLoad), .seed(seed),
    .ack(ackA), .busy(busyA), .done(doneA), .valid(validA), .rand_out(randA)
  );

  xorshift_engine dutB (
    .clk(clk), .rst(rst), .start(start), .seed_load(seedLoad), .seed(seed),
    .ack(ackB), .busy(busyB), .done(doneB), .valid(validB), .rand_out(randB)
  );

  always #5 clk = ~clk;

  // Reference xorshift32 with the 13/17/5 triple
  function automatic logic [31:0] xsModel(input logic [31:0] s, input int rounds);
    logic [31:0] x;
    x = s;
    for (int i = 0; i < rounds; i++) begin
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
    end
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor A: pop and compare on every done pulse, hold-check rand_out while valid
  always @(negedge clk) begin
    if (!rst) begin
      if (doneA) begin
        checkOutput("doneOneCycleA", 32'(prevDoneA), 32'd0);
        if (qA.size() == 0) begin
          checkOutput("unexpectedDoneA", 32'd1, 32'd0);
        end else begin
          ExpT e;
          e = qA.pop_front();
          checkOutput("randA", randA, e.value);
          checkOutput("latencyA", 32'(($time - e.startTime) / 10), 32'(3 * RoundsA + 1));
          checkOutput("validWithDoneA", 32'(validA), 32'd1);
        end
        holdA = randA;
      end else if (validA) begin
        checkOutput("stableA", randA, holdA);
      end
      prevDoneA = doneA;
    end
  end

  // Monitor B: same checks for the default-configuration instance
  always @(negedge clk) begin
    if (!rst) begin
      if (doneB) begin
        checkOutput("doneOneCycleB", 32'(prevDoneB), 32'd0);
        if (qB.size() == 0) begin
          checkOutput("unexpectedDoneB", 32'd1, 32'd0);
        end else begin
          ExpT e;
          e = qB.pop_front();
          checkOutput("randB", randB, e.value);
          checkOutput("latencyB", 32'(($time - e.startTime) / 10), 32'(3 * RoundsB + 1));
          checkOutput("validWithDoneB", 32'(validB), 32'd1);
        end
        holdB = randB;
      end else if (validB) begin
        checkOutput("stableB", randB, holdB);
      end
      prevDoneB = doneB;
    end
  end

  task automatic applyReset();
    rst = 1'b1;
    #1;
    checkOutput("resetStatusA", {29'd0, busyA, doneA, validA}, 32'd0);
    checkOutput("resetRandA", randA, 32'd0);
    checkOutput("resetStatusB", {29'd0, busyB, doneB, validB}, 32'd0);
    checkOutput("resetRandB", randB, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    qA.delete();
    qB.delete();
    stA = 32'd1;
    stB = 32'd1;
  endtask

  // Wait (bounded) for an instance to present valid, optionally jamming start/seed_load,
  // then ack after a delay and confirm valid drops right after the ack edge
  task automatic waitAndAck(input bit which, input int ackDelay, input bit disturb);
    int n;
    n = 0;
    while (((which == 1'b0) ? validA : validB) == 1'b0 && n < 100) begin
      if (disturb) begin start = 1'b1; seedLoad = 1'b1; seed = 32'hCAFEF00D; end
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checkOutput(which ? "timeoutB" : "timeoutA", 32'd1, 32'd0);
    end else begin
      for (int d = 0; d < ackDelay; d++) begin
        if (disturb) begin start = 1'b1; seedLoad = 1'b1; end
        @(posedge clk); #1;
      end
      start    = 1'b0;
      seedLoad = 1'b0;
      if (which == 1'b0) ackA = 1'b1; else ackB = 1'b1;
      @(posedge clk); #1;
      ackA = 1'b0;
      ackB = 1'b0;
      checkOutput(which ? "validDropB" : "validDropA", 32'(which ? validB : validA), 32'd0);
    end
  endtask

  task automatic applyStimulus(input bit doSeed, input logic [31:0] seedVal,
                               input logic [31:0] expA, input logic [31:0] expB,
                               input int ackDelay, input bit disturb);
    ExpT e;
    start    = 1'b1;
    seedLoad = doSeed;
    seed     = seedVal;
    e.startTime = $time;
    e.value = expA; qA.push_back(e);
    e.value = expB; qB.push_back(e);
    @(posedge clk); #1;
    start    = 1'b0;
    seedLoad = 1'b0;
    checkOutput("busyAfterStartA", 32'(busyA), 32'd1);
    waitAndAck(1'b0, ackDelay, disturb);
    waitAndAck(1'b1, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seedLoad = 1'b0; seed = '0; ackA = 1'b0; ackB = 1'b0;
    @(posedge clk); #1;
    applyReset();

    // Basic run from RESET_SEED and a chained second run
    stA = 32'h00042021; stB = xsModel(stB, RoundsB);
    applyStimulus(1'b0, '0, stA, stB, 0, 1'b0);
    stA = 32'h04080601; stB = xsModel(stB, RoundsB);
    applyStimulus(1'b0, '0, stA, stB, 1, 1'b0);

    // seed_load together with start
    stA = xsModel(32'h12345678, RoundsA); stB = xsModel(32'h12345678, RoundsB);
    applyStimulus(1'b1, 32'h12345678, stA, stB, 2, 1'b0);

    // start and seed_load jammed while busy/waiting, ack held off 5 cycles
    stA = xsModel(stA, RoundsA); stB = xsModel(stB, RoundsB);
    applyStimulus(1'b0, '0, stA, stB, 5, 1'b1);

    // seed_load alone in IDLE, then a plain start
    seedLoad = 1'b1; seed = 32'hDEADBEEF;
    @(posedge clk); #1;
    seedLoad = 1'b0;
    stA = xsModel(32'hDEADBEEF, RoundsA); stB = xsModel(32'hDEADBEEF, RoundsB);
    applyStimulus(1'b0, '0, stA, stB, 0, 1'b0);

    // Zero seed
`ifdef XS_ZERO_SEED_GUARD_EN
    stA = 32'h00042021; stB = xsModel(32'd1, RoundsB);
`else
    stA = 32'd0; stB = 32'd0;
`endif
    applyStimulus(1'b1, 32'd0, stA, stB, 0, 1'b0);

    // Reset asserted while both instances are in XB
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    applyReset();
    stA = 32'h00042021; stB = xsModel(32'd1, RoundsB);
    applyStimulus(1'b0, '0, stA, stB, 0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("queuesEmpty", 32'(qA.size() + qB.size()), 32'd0);
    checkOutput("idleAtEnd", {28'd0, busyA, validA, busyB, validB}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
